// File: rtl/reg_file_sb.sv
// Integer register file with a per-register busy scoreboard for in-order issue.
// Optional forwarding of the in-flight write-back onto the read ports and busy flags.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en,
    input  logic [$clog2(NREG)-1:0]  rd_index,
    input  logic [XLEN-1:0]          wb_data,
    input  logic [$clog2(NREG)-1:0]  rs1_index,
    input  logic [$clog2(NREG)-1:0]  rs2_index,
    output logic [XLEN-1:0]          rs1_data_out,
    output logic [XLEN-1:0]          rs2_data_out,
    input  logic                     issue_en,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    input  logic                     flush,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     stall
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            fwd1;
    logic            fwd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i[AW-1:0]] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_en && rd_index != '0) begin
                regs[rd_index] <= wb_data;
            end
            if (flush) begin
                busy <= '0;
            end else begin
                if (wb_en) begin
                    busy[rd_index] <= 1'b0;
                end
                // Issue is assigned last so a new producer beats a same-index write-back.
                if (issue_en && issue_rd != '0) begin
                    busy[issue_rd] <= 1'b1;
                end
            end
        end
    end

    // Forwarding is gated by rst so outputs read zero while reset is held.
    assign fwd1 = (BYPASS != 0) && rst && wb_en && (rd_index == rs1_index);
    assign fwd2 = (BYPASS != 0) && rst && wb_en && (rd_index == rs2_index);

    assign rs1_data_out = (rs1_index == '0) ? '0 : (fwd1 ? wb_data : regs[rs1_index]);
    assign rs2_data_out = (rs2_index == '0) ? '0 : (fwd2 ? wb_data : regs[rs2_index]);

    assign rs1_busy = busy[rs1_index] & ~fwd1;
    assign rs2_busy = busy[rs2_index] & ~fwd2;
    assign stall    = rs1_busy | rs2_busy;

endmodule
